ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter: the send direction of the keyboard link, complementing the existing receive path (PS2_Interface).
- Sends one command byte to the keyboard, e.g. 0xED set-LEDs or 0xFF reset, using the standard inhibit, request-to-send, device-clocked frame and ACK sequence.
- Drives the open-drain ps2_clock and ps2_data lines through pull-low enables. The top level ties each pad to 0 when its enable is high and to z otherwise.
- tx_busy tells the receive path to ignore line activity during a transmission.

Parameters:
- INHIBIT_CYCLES, 6000: clock-low inhibit time in clock cycles (120 us at 50 MHz).
- TIMEOUT_CYCLES, 1000000: maximum cycles from clock release to ACK (20 ms at 50 MHz).
- SYNC_STAGES, 2: synchronizer flops on each PS/2 input (must be 2 or more).

Ports:
- clock, input, 1: system clock, 50 MHz.
- reset, input, 1: asynchronous, active-high reset.
- tx_data, input, 8: byte to send. Captured when tx_start is accepted.
- tx_start, input, 1: one-cycle start request. Accepted only in IDLE.
- tx_busy, output, 1: high from acceptance until return to IDLE.
- tx_done, output, 1: one-cycle pulse, byte acknowledged by the device.
- tx_error, output, 1: one-cycle pulse, transaction failed.
- err_code, output, 2: 01 = timeout, 10 = NACK or missing ACK. Held until the next accept.
- ps2_clk_in, input, 1: ps2_clock pad input.
- ps2_data_in, input, 1: ps2_data pad input.
- ps2_clk_oe, output, 1: 1 pulls ps2_clock low.
- ps2_data_oe, output, 1: 1 pulls ps2_data low.

Behaviour:
- Reset (asynchronous, active-high), value of every output:
  - ps2_clk_oe = 0 and ps2_data_oe = 0 immediately, so both lines are released.
  - tx_busy = 0, tx_done = 0, tx_error = 0, err_code = 00.
  - State = IDLE.
  - Reset in mid-frame abandons the frame with no done or error pulse.
- Input conditioning:
  - ps2_clk_in and ps2_data_in each pass through SYNC_STAGES flops.
  - fall = synchronized clock was 1 last cycle and is 0 this cycle.
- Frame bits:
  - shift register = {stop = 1, parity = ~^tx_data (odd parity), tx_data}, LSB first.
  - ps2_data_oe = ~current bit.
- IDLE:
  - On tx_start: latch tx_data, set tx_busy = 1 in the next cycle, clear err_code, go to INHIBIT.
  - tx_start in any other state is ignored. No queueing.
- INHIBIT:
  - ps2_clk_oe = 1 for INHIBIT_CYCLES cycles.
  - ps2_data_oe = 1 in the final inhibit cycle (start bit), while clk_oe is still 1.
  - Then go to REQ.
- REQ:
  - ps2_clk_oe = 0, ps2_data_oe = 1.
  - Timeout counter starts at 0.
  - bit_cnt = 0.
  - Go to SHIFT.
- SHIFT, on each fall:
  - Falls 1 to 8 present data bits 0 to 7.
  - Fall 9 presents parity.
  - Fall 10 releases data (stop bit) and goes to ACK.
  - The output enable changes on the cycle after fall is detected.
- ACK:
  - On the next fall (fall 11), sample synchronized data.
  - 0: go to WAIT_IDLE.
  - 1: tx_error with err_code = 10, go to IDLE.
- WAIT_IDLE:
  - Wait until synchronized clock and data are both 1.
  - Then pulse tx_done for one cycle and go to IDLE.
  - tx_busy = 0 in the same cycle as the tx_done pulse.
- Timeout:
  - Counts every cycle from REQ until leaving WAIT_IDLE.
  - Reaching TIMEOUT_CYCLES in any of REQ, SHIFT, ACK or WAIT_IDLE causes:
    - both enables = 0,
    - tx_error pulse with err_code = 01,
    - return to IDLE.
  - Timeout has priority over a simultaneous fall.
- tx_error:
  - tx_busy = 0 in the same cycle as the tx_error pulse.
  - tx_done and tx_error are never both high.
- Line contention: a fall during INHIBIT (device still clocking) is ignored, and the inhibit count continues.
- Sizing:
  - Counters are $clog2(max parameter) + 1 bits wide.
  - Timeout counter saturates.
- Latency from tx_start to tx_done is INHIBIT_CYCLES + device frame time (about 11 PS/2 clocks) + synchronizer delay.

Decomposition:
- Shared package ps2_pkg:
  - state encoding: IDLE, INHIBIT, REQ, SHIFT, ACK, WAIT_IDLE.
  - err_code constants: ERR_NONE = 00, ERR_TIMEOUT = 01, ERR_NACK = 10.
  - PS/2 command constants: CMD_SET_LEDS = 8'hED, CMD_RESET = 8'hFF, CMD_ECHO = 8'hEE.
- One sub-module, ps2_line_sync: the parameterized synchronizer plus falling-edge detector, reusable by the receive side.
- Top-level tristate pads stay in the skeleton.

Test Plan:
- Send tx_data = 0xED. Device BFM clocks at 12.5 kHz and ACKs.
  - Required: clk_oe held for 6000 cycles, then data bits 1,0,1,1,0,1,1,1.
  - Required: parity 1, then stop (data released).
  - Required: tx_done pulses exactly once; tx_busy falls in the same cycle.
  - Required: err_code = 00.
- Send tx_data = 0x00.
  - Required: parity bit = 1.
  - Required: BFM reconstructs 0x00 with valid odd parity.
- BFM never clocks after REQ.
  - Required: after 1000000 cycles, tx_error pulses with err_code = 01.
  - Required: both enables = 0, tx_busy = 0.
- BFM leaves data high at fall 11 (NACK).
  - Required: tx_error pulses with err_code = 10; tx_done stays 0.
- Second tx_start during SHIFT with a different byte.
  - Required: ignored; the frame carries the first byte and exactly one tx_done pulses.
- Assert reset after fall 5.
  - Required: both enables drop in the same timestep; no done or error pulse.
  - Required: a following tx_start of 0xFF completes normally with tx_done.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host link: FSM encoding, error codes,
// common keyboard command bytes and the frame builder.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    REQ       = 3'd2,
    SHIFT     = 3'd3,
    ACK       = 3'd4,
    WAIT_IDLE = 3'd5
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_NACK    = 2'b10;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_ECHO     = 8'hEE;

  // Bits shifted out LSB first after the start bit: data, odd parity, stop.
  function automatic logic [9:0] frame_bits(input logic [7:0] data);
    return {1'b1, ~^data, data};
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Synchronizes the PS/2 clock and data pads into the system clock domain and
// flags the cycle on which the synchronized clock falls.
module ps2_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic clk_in,
  input  logic data_in,
  output logic clk_s,
  output logic data_s,
  output logic fall
);

  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
  logic                   clk_prev_q, clk_prev_d;

  always_comb begin
    clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], clk_in};
    data_sync_d = {data_sync_q[SYNC_STAGES-2:0], data_in};
    clk_prev_d  = clk_sync_q[SYNC_STAGES-1];
  end

  // Idle PS/2 lines are pulled high, so reset to the released level.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      clk_prev_q  <= clk_prev_d;
    end
  end

  assign clk_s  = clk_sync_q[SYNC_STAGES-1];
  assign data_s = data_sync_q[SYNC_STAGES-1];
  assign fall   = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, device-clocked
// frame, ACK check and bus-idle wait, driving the pads via pull-low enables.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 6000,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  output logic [1:0] err_code,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int MAX_CYC = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;
  localparam logic [CNT_W-1:0] INH_LAST  = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] INH_START = CNT_W'(INHIBIT_CYCLES - 2);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_MAX    = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic clk_s, data_s, fall;

  ps2_line_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_line_sync (
    .clock  (clock),
    .reset  (reset),
    .clk_in (ps2_clk_in),
    .data_in(ps2_data_in),
    .clk_s  (clk_s),
    .data_s (data_s),
    .fall   (fall)
  );

  state_t           state_q, state_d;
  logic [9:0]       shift_q, shift_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] inh_cnt_q, inh_cnt_d;
  logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic [1:0]       err_code_q, err_code_d;
  logic             clk_oe_q, clk_oe_d;
  logic             data_oe_q, data_oe_d;
  logic             timed_out;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    inh_cnt_d  = inh_cnt_q;
    to_cnt_d   = to_cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    error_d    = 1'b0;
    err_code_d = err_code_q;
    clk_oe_d   = clk_oe_q;
    data_oe_d  = data_oe_q;
    timed_out  = 1'b0;

    // One watchdog covers the whole device-clocked part of the transaction.
    if (state_q inside {REQ, SHIFT, ACK, WAIT_IDLE}) begin
      if (to_cnt_q != TO_MAX) to_cnt_d = to_cnt_q + CNT_ONE;
      timed_out = (to_cnt_q >= TO_LAST);
    end

    if (timed_out) begin
      state_d    = IDLE;
      busy_d     = 1'b0;
      error_d    = 1'b1;
      err_code_d = ERR_TIMEOUT;
      clk_oe_d   = 1'b0;
      data_oe_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
          if (tx_start) begin
            shift_d    = frame_bits(tx_data);
            inh_cnt_d  = '0;
            busy_d     = 1'b1;
            err_code_d = ERR_NONE;
            clk_oe_d   = 1'b1;
            data_oe_d  = (INHIBIT_CYCLES == 1);
            state_d    = INHIBIT;
          end
        end
        INHIBIT: begin
          // Falls seen here come from a device still clocking; ignore them.
          inh_cnt_d = inh_cnt_q + CNT_ONE;
          if (inh_cnt_q == INH_START) data_oe_d = 1'b1;
          if (inh_cnt_q == INH_LAST) begin
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b1;
            to_cnt_d  = '0;
            bit_cnt_d = '0;
            state_d   = REQ;
          end
        end
        REQ: begin
          state_d = SHIFT;
        end
        SHIFT: begin
          if (fall) begin
            data_oe_d = ~shift_q[0];
            shift_d   = {1'b1, shift_q[9:1]};
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd9) state_d = ACK;
          end
        end
        ACK: begin
          if (fall) begin
            if (!data_s) begin
              state_d = WAIT_IDLE;
            end else begin
              state_d    = IDLE;
              busy_d     = 1'b0;
              error_d    = 1'b1;
              err_code_d = ERR_NACK;
              clk_oe_d   = 1'b0;
              data_oe_d  = 1'b0;
            end
          end
        end
        WAIT_IDLE: begin
          if (clk_s && data_s) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
        default: begin
          state_d   = IDLE;
          busy_d    = 1'b0;
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      shift_q    <= '1;
      bit_cnt_q  <= '0;
      inh_cnt_q  <= '0;
      to_cnt_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      err_code_q <= ERR_NONE;
      clk_oe_q   <= 1'b0;
      data_oe_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      inh_cnt_q  <= inh_cnt_d;
      to_cnt_q   <= to_cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      err_code_q <= err_code_d;
      clk_oe_q   <= clk_oe_d;
      data_oe_q  <= data_oe_d;
    end
  end

  assign tx_busy     = busy_q;
  assign tx_done     = done_q;
  assign tx_error    = error_q;
  assign err_code    = err_code_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: a device model on wired-AND lines rebuilds
// each frame and checks it against bytes queued when tx_start is issued.
module tb_ps2_host_tx;

  localparam int INH  = 60;
  localparam int TO   = 3000;
  localparam int HALF = 40;

  logic       clock;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy, tx_done, tx_error;
  logic [1:0] err_code;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       bfm_clk, bfm_data;
  logic       clk_line, data_line;

  assign clk_line  = ~ps2_clk_oe & bfm_clk;
  assign data_line = ~ps2_data_oe & bfm_data;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TO),
    .SYNC_STAGES   (2)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .tx_error   (tx_error),
    .err_code   (err_code),
    .ps2_clk_in (clk_line),
    .ps2_data_in(data_line),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];

  int cyc = 0, done_cnt = 0, err_cnt = 0, both_cnt = 0;
  int inh_run = 0, inh_both_run = 0, last_inh = 0, last_inh_both = 0;
  int req_cyc = 0, err_cyc = 0;
  logic busy_at_done = 1'b0, busy_at_err = 1'b0;
  logic [1:0] oe_at_err = 2'b00;

  always @(negedge clock) begin
    cyc <= cyc + 1;
    if (tx_done) begin
      done_cnt     <= done_cnt + 1;
      busy_at_done <= tx_busy;
    end
    if (tx_error) begin
      err_cnt     <= err_cnt + 1;
      busy_at_err <= tx_busy;
      oe_at_err   <= {ps2_clk_oe, ps2_data_oe};
      err_cyc     <= cyc;
    end
    if (tx_done && tx_error) both_cnt <= both_cnt + 1;
    if (ps2_clk_oe) begin
      inh_run      <= inh_run + 1;
      inh_both_run <= inh_both_run + (ps2_data_oe ? 1 : 0);
    end else if (inh_run != 0) begin
      last_inh      <= inh_run;
      last_inh_both <= inh_both_run;
      inh_run       <= 0;
      inh_both_run  <= 0;
      req_cyc       <= cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input bit push);
    @(negedge clock);
    tx_data  = b;
    tx_start = 1'b1;
    @(negedge clock);
    tx_start = 1'b0;
    if (push) exp_q.push_back(b);
  endtask

  // Device side: wait for request-to-send, then generate nfalls clock pulses,
  // sampling data while the clock is high; ACK by holding data low at fall 11.
  task automatic device_frame(input bit do_ack, input int nfalls,
                              output logic [10:0] bits, output bit rts_ok);
    int guard;
    bits   = '1;
    rts_ok = 1'b0;
    guard  = 0;
    while (!ps2_clk_oe && guard < 5000) begin @(negedge clock); guard++; end
    while (ps2_clk_oe && guard < 5000) begin @(negedge clock); guard++; end
    if (guard >= 5000) return;
    rts_ok = 1'b1;
    repeat (HALF) @(negedge clock);
    bits[0] = data_line;
    for (int k = 1; k <= nfalls; k++) begin
      if (k == 11) begin
        bfm_data = do_ack ? 1'b0 : 1'b1;
        repeat (4) @(negedge clock);
      end
      bfm_clk = 1'b0;
      repeat (HALF) @(negedge clock);
      bfm_clk = 1'b1;
      repeat (HALF) @(negedge clock);
      if (k <= 10) bits[k] = data_line;
    end
    bfm_data = 1'b1;
  endtask

  task automatic wait_outcome(input int d0, input int e0, input int budget);
    int n;
    n = 0;
    while (done_cnt == d0 && err_cnt == e0 && n < budget) begin
      @(negedge clock);
      n++;
    end
    check("outcome_seen", 32'(n < budget), 1);
    repeat (20) @(negedge clock);
  endtask

  task automatic check_frame(input logic [10:0] bits);
    logic [7:0] e;
    int ones;
    check("sb_size", exp_q.size(), 1);
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(e[i]);
    check("start_bit", bits[0], 0);
    check("data_byte", bits[8:1], e);
    check("parity", bits[9], 32'(ones % 2 == 0));
    check("stop_bit", bits[10], 1);
  endtask

  initial begin
    logic [10:0] bits;
    bit ok;
    int d0, e0, lat;

    reset = 1'b1; tx_start = 1'b0; tx_data = 8'h00; bfm_clk = 1'b1; bfm_data = 1'b1;
    #1;
    check("rst_clk_oe", ps2_clk_oe, 0);
    check("rst_data_oe", ps2_data_oe, 0);
    check("rst_busy", tx_busy, 0);
    check("rst_done", tx_done, 0);
    check("rst_error", tx_error, 0);
    check("rst_err_code", err_code, 0);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);

    // 0xED with ACK
    d0 = done_cnt; e0 = err_cnt;
    send(8'hED, 1);
    check("busy_after_start", tx_busy, 1);
    device_frame(1, 11, bits, ok);
    check("rts_ed", ok, 1);
    check("inhibit_len", last_inh, INH);
    check("start_in_inhibit", last_inh_both, 1);
    wait_outcome(d0, e0, 500);
    check_frame(bits);
    check("done_ed", done_cnt - d0, 1);
    check("err_ed", err_cnt - e0, 0);
    check("busy_at_done", busy_at_done, 0);
    check("err_code_ed", err_code, 0);
    check("busy_idle_ed", tx_busy, 0);

    // 0x00 with ACK: odd parity must be 1
    d0 = done_cnt; e0 = err_cnt;
    send(8'h00, 1);
    device_frame(1, 11, bits, ok);
    check("rts_00", ok, 1);
    wait_outcome(d0, e0, 500);
    check("parity_00", bits[9], 1);
    check_frame(bits);
    check("done_00", done_cnt - d0, 1);

    // Device never clocks after request-to-send
    d0 = done_cnt; e0 = err_cnt;
    send(8'h55, 0);
    device_frame(1, 0, bits, ok);
    check("rts_to", ok, 1);
    wait_outcome(d0, e0, TO + 500);
    check("err_to", err_cnt - e0, 1);
    check("done_to", done_cnt - d0, 0);
    check("err_code_to", err_code, 1);
    check("oe_at_err_to", oe_at_err, 0);
    check("busy_at_err_to", busy_at_err, 0);
    lat = err_cyc - req_cyc;
    check("to_latency", 32'(lat >= TO - 1 && lat <= TO + 1), 1);

    // NACK: data left high at fall 11
    d0 = done_cnt; e0 = err_cnt;
    send(8'h12, 1);
    device_frame(0, 11, bits, ok);
    wait_outcome(d0, e0, 500);
    check_frame(bits);
    check("err_nack", err_cnt - e0, 1);
    check("done_nack", done_cnt - d0, 0);
    check("err_code_nack", err_code, 2);
    check("busy_at_err_nack", busy_at_err, 0);

    // Second tx_start during SHIFT is ignored
    d0 = done_cnt; e0 = err_cnt;
    send(8'h3C, 1);
    fork
      device_frame(1, 11, bits, ok);
      begin
        repeat (INH + HALF + 8 * HALF) @(negedge clock);
        tx_data  = 8'h99;
        tx_start = 1'b1;
        @(negedge clock);
        tx_start = 1'b0;
      end
    join
    wait_outcome(d0, e0, 500);
    check_frame(bits);
    check("done_ignored", done_cnt - d0, 1);
    check("busy_after_ignored", tx_busy, 0);
    check("clk_oe_after_ignored", ps2_clk_oe, 0);

    // Reset after fall 5, then a normal 0xFF
    d0 = done_cnt; e0 = err_cnt;
    send(8'hA5, 0);
    device_frame(1, 5, bits, ok);
    check("pre_reset_data_oe", ps2_data_oe, 1);
    reset = 1'b1;
    #1;
    check("reset_clk_oe", ps2_clk_oe, 0);
    check("reset_data_oe", ps2_data_oe, 0);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (50) @(negedge clock);
    check("reset_no_done", done_cnt - d0, 0);
    check("reset_no_err", err_cnt - e0, 0);
    check("reset_busy", tx_busy, 0);
    d0 = done_cnt; e0 = err_cnt;
    send(8'hFF, 1);
    device_frame(1, 11, bits, ok);
    wait_outcome(d0, e0, 500);
    check_frame(bits);
    check("done_ff", done_cnt - d0, 1);
    check("err_ff", err_cnt - e0, 0);
    check("err_code_ff", err_code, 0);

    check("never_both", both_cnt, 0);
    check("sb_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
